param_lock: RTL and testbench
=============================

PARAM_LOCK -- requirements
Module: param_lock

Interface
REQ-001 Parameter DIGIT_W, default 4, width of one password digit.
REQ-002 Parameter MAX_LEN, default 8, maximum digits per password (legal 2..16).
REQ-003 Parameter MAX_ATTEMPTS, default 3, consecutive failures before lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 16, lockout duration in clk cycles.
REQ-005 Parameter UNLOCK_CYCLES, default 16, unlock hold time in clk cycles.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 system_reset_n  in  1  asynchronous, active-low reset.
REQ-008 input_btn  in  1  active-high level; append digit to entry buffer.
REQ-009 store_btn  in  1  active-high level; append digit to new-key buffer.
REQ-010 submit_btn  in  1  active-high level; check entry or commit new key.
REQ-011 cancel_btn  in  1  active-high level; abort entry/store, or relock early.
REQ-012 digit  in  DIGIT_W  digit value sampled on an accepted button edge.
REQ-013 unlock  out  1  high while in UNLOCK.
REQ-014 lockout  out  1  high while in LOCKOUT.
REQ-015 fail_pulse  out  1  one-cycle pulse per failed check.
REQ-016 cur_state  out  3  state encoding per REQ-019.
REQ-017 entry_count  out  clog2(MAX_LEN+1)  digits in the active buffer.
REQ-018 attempts_left  out  clog2(MAX_ATTEMPTS+1)  failures remaining before lockout.

Function
REQ-019 FSM encoding: IDLE=0, ENTER=1, STORE=2, CHECK=3, UNLOCK=4, FAIL=5, LOCKOUT=6; unused codes go to IDLE.
REQ-020 Each button acts only on its rising edge, detected against a registered copy of the previous level; one action per press.
REQ-021 Same-cycle edge priority: cancel > submit > input > store.
REQ-022 IDLE: an input edge captures digit as entry[0], sets entry_count=1 and goes to ENTER; a store edge does the same into the key buffer and goes to STORE.
REQ-023 ENTER/STORE: a matching button edge appends digit at index entry_count while entry_count<MAX_LEN; at MAX_LEN further digits are ignored (saturate, no wrap).
REQ-024 ENTER: submit edge goes to CHECK; cancel edge clears the buffer and goes to IDLE with no fail_pulse.
REQ-025 STORE: submit edge commits the buffer to the stored key, sets stored_len=entry_count and attempts_left=MAX_ATTEMPTS, then goes to IDLE; cancel leaves the stored key unchanged.
REQ-026 CHECK lasts one cycle. Match requires stored_len!=0, entry_count==stored_len, and equality of digits 0..stored_len-1. Match goes to UNLOCK and reloads attempts_left; mismatch decrements attempts_left and goes to FAIL. The entry buffer clears on exit.
REQ-027 Latency: submit edge sampled at edge n gives CHECK at n+1 and unlock or fail_pulse asserted from edge n+2.
REQ-028 FAIL lasts one cycle with fail_pulse=1, then goes to LOCKOUT if attempts_left==0, else IDLE.
REQ-029 UNLOCK holds unlock=1 for exactly UNLOCK_CYCLES cycles, then goes to IDLE; a cancel edge exits early; other buttons are ignored.
REQ-030 LOCKOUT holds lockout=1 for exactly LOCKOUT_CYCLES cycles and ignores all buttons including cancel; on exit it reloads attempts_left=MAX_ATTEMPTS and goes to IDLE.

Reset
REQ-031 While system_reset_n=0: state=IDLE; entry_count, stored_len, all buffer and key digits, timers, unlock, lockout and fail_pulse are 0; attempts_left=MAX_ATTEMPTS. Reset applies immediately in any state, including mid-LOCKOUT or mid-UNLOCK.
REQ-032 Registered button copies reset to 0, so a button held high through reset release produces an edge.

Configuration
REQ-033 Macro LOCK_REKEY_EN defined: a store edge in IDLE is ignored unless stored_len==0; a store edge during UNLOCK drops unlock and enters STORE with that digit.
REQ-034 LOCK_REKEY_EN undefined: STORE is entered from IDLE freely, and store edges in UNLOCK are ignored.

Verification (MAX_LEN=4, MAX_ATTEMPTS=2, LOCKOUT_CYCLES=8, UNLOCK_CYCLES=4)
REQ-035 Store 3,7,1 + submit, then enter 3,7,1 + submit -> unlock high exactly 4 cycles starting 2 edges after submit; attempts_left=2.
REQ-036 Key 3,7,1; enter 3,7 + submit -> one fail_pulse, attempts_left=1, unlock stays 0; a second wrong entry -> lockout high 8 cycles, input presses ignored (entry_count=0), then attempts_left=2.
REQ-037 Enter 5 digits -> entry_count saturates at 4; submitting with key 1,2,3,4 and digits 1,2,3,4,9 -> unlock.
REQ-038 Submit and cancel edges in the same cycle in ENTER -> IDLE, no fail_pulse, attempts_left unchanged.
REQ-039 system_reset_n low at lockout cycle 3 -> lockout=0 immediately; after release, any entry + submit -> fail_pulse (stored_len=0).
REQ-040 With LOCK_REKEY_EN: store edge in IDLE with key present -> state stays 0; store edge during UNLOCK -> cur_state=2, unlock=0.

Source files
------------

// File: rtl/param_lock.sv
// Parameterised digit-code lock: one working digit buffer, stored key, one-cycle check, timed unlock/lockout.
// Optional macro LOCK_REKEY_EN: a new key may only be stored when none exists, or from UNLOCK.
module param_lock #(
  parameter int DIGIT_W        = 4,
  parameter int MAX_LEN        = 8,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int UNLOCK_CYCLES  = 16
) (
  input  logic                              clk,
  input  logic                              system_reset_n,
  input  logic                              input_btn,
  input  logic                              store_btn,
  input  logic                              submit_btn,
  input  logic                              cancel_btn,
  input  logic [DIGIT_W-1:0]                digit,
  output logic                              unlock,
  output logic                              lockout,
  output logic                              fail_pulse,
  output logic [2:0]                        cur_state,
  output logic [$clog2(MAX_LEN+1)-1:0]      entry_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left
);

  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int ATT_W   = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(MAX_LEN);
  localparam logic [ATT_W-1:0] ATT_FULL     = ATT_W'(MAX_ATTEMPTS);
  localparam logic [TMR_W-1:0] UNLOCK_LAST  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTER   = 3'd1;
  localparam logic [2:0] S_STORE   = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_UNLOCK  = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;
  localparam logic [2:0] S_LOCKOUT = 3'd6;

  logic [2:0]         state;
  logic [3:0]         prev_q;
  logic [3:0]         levels;
  logic [3:0]         edges;
  logic               ev_cancel, ev_submit, ev_input, ev_store;
  logic               store_ok;
  logic               rekey;
  logic               append_en;
  logic               key_match;
  logic [CNT_W-1:0]   stored_len;
  logic [TMR_W-1:0]   timer;
  logic [DIGIT_W-1:0] entry_buf [MAX_LEN];
  logic [DIGIT_W-1:0] key_mem   [MAX_LEN];

`ifdef LOCK_REKEY_EN
  assign store_ok = (stored_len == '0);
  assign rekey    = 1'b1;
`else
  assign store_ok = 1'b1;
  assign rekey    = 1'b0;
`endif

  // Bit order {cancel, submit, input, store} is also the priority order.
  assign levels = {cancel_btn, submit_btn, input_btn, store_btn};
  assign edges  = levels & ~prev_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    ev_cancel = 1'b0;
    ev_submit = 1'b0;
    ev_input  = 1'b0;
    ev_store  = 1'b0;
    if (edges[3])      ev_cancel = 1'b1;
    else if (edges[2]) ev_submit = 1'b1;
    else if (edges[1]) ev_input  = 1'b1;
    else if (edges[0]) ev_store  = 1'b1;
  end

  // Buffer is empty whenever a new entry starts, so starting and appending are the same write.
  always_comb begin
    append_en = 1'b0;
    case (state)
      S_IDLE:   append_en = ev_input || (ev_store && store_ok);
      S_ENTER:  append_en = ev_input;
      S_STORE:  append_en = ev_store;
      S_UNLOCK: append_en = ev_store && rekey;
      default:  append_en = 1'b0;
    endcase
  end

  always_comb begin
    key_match = (stored_len != '0) && (entry_count == stored_len);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((CNT_W'(i) < stored_len) && (entry_buf[i] != key_mem[i])) key_match = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state         <= S_IDLE;
      prev_q        <= '0;
      entry_count   <= '0;
      stored_len    <= '0;
      attempts_left <= ATT_FULL;
      timer         <= '0;
      // NOTE: the digit arrays are part of the reset state, so they are cleared here like any register.
      for (int i = 0; i < MAX_LEN; i++) begin
        entry_buf[i] <= '0;
        key_mem[i]   <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; later writes in this block win.
      prev_q <= levels;

      if (append_en && (entry_count < CNT_FULL)) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (CNT_W'(i) == entry_count) entry_buf[i] <= digit;
        end
        entry_count <= entry_count + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (ev_input)                  state <= S_ENTER;
          else if (ev_store && store_ok) state <= S_STORE;
        end
        S_ENTER, S_STORE: begin
          if (ev_cancel || (ev_submit && state == S_STORE)) begin
            if (ev_submit) begin
              for (int i = 0; i < MAX_LEN; i++) key_mem[i] <= entry_buf[i];
              stored_len    <= entry_count;
              attempts_left <= ATT_FULL;
            end
            for (int i = 0; i < MAX_LEN; i++) entry_buf[i] <= '0;
            entry_count <= '0;
            state       <= S_IDLE;
          end else if (ev_submit) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          for (int i = 0; i < MAX_LEN; i++) entry_buf[i] <= '0;
          entry_count <= '0;
          if (key_match) begin
            attempts_left <= ATT_FULL;
            timer         <= UNLOCK_LAST;
            state         <= S_UNLOCK;
          end else begin
            if (attempts_left != '0) attempts_left <= attempts_left - ATT_W'(1);
            state <= S_FAIL;
          end
        end
        S_FAIL: begin
          if (attempts_left == '0) begin
            timer <= LOCKOUT_LAST;
            state <= S_LOCKOUT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_UNLOCK: begin
          if (ev_cancel)              state <= S_IDLE;
          else if (ev_store && rekey) state <= S_STORE;
          else if (timer == '0)       state <= S_IDLE;
          else                        timer <= timer - TMR_W'(1);
        end
        S_LOCKOUT: begin
          if (timer == '0) begin
            attempts_left <= ATT_FULL;
            state         <= S_IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cur_state  = state;
  assign unlock     = (state == S_UNLOCK);
  assign lockout    = (state == S_LOCKOUT);
  assign fail_pulse = (state == S_FAIL);

endmodule

// File: tb/tb_param_lock.sv
// Bench for param_lock: directed vector table, hand-written corner sequences, then random stimulus vs a queue model.
module tb_param_lock;

  localparam int DIGIT_W = 4;
  localparam int MAX_LEN = 4;
  localparam int MAX_ATT = 2;
  localparam int LO_CYC  = 8;
  localparam int UN_CYC  = 4;

`ifdef LOCK_REKEY_EN
  localparam bit REKEY = 1'b1;
`else
  localparam bit REKEY = 1'b0;
`endif

  localparam logic [3:0] B_C  = 4'b1000;
  localparam logic [3:0] B_S  = 4'b0100;
  localparam logic [3:0] B_I  = 4'b0010;
  localparam logic [3:0] B_ST = 4'b0001;
  localparam logic [3:0] B_0  = 4'b0000;

  logic               clk;
  logic               system_reset_n;
  logic               input_btn, store_btn, submit_btn, cancel_btn;
  logic [DIGIT_W-1:0] digit;
  logic               unlock, lockout, fail_pulse;
  logic [2:0]         cur_state;
  logic [2:0]         entry_count;
  logic [1:0]         attempts_left;

  param_lock #(
    .DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN), .MAX_ATTEMPTS(MAX_ATT),
    .LOCKOUT_CYCLES(LO_CYC), .UNLOCK_CYCLES(UN_CYC)
  ) dut (
    .clk(clk), .system_reset_n(system_reset_n),
    .input_btn(input_btn), .store_btn(store_btn), .submit_btn(submit_btn), .cancel_btn(cancel_btn),
    .digit(digit), .unlock(unlock), .lockout(lockout), .fail_pulse(fail_pulse),
    .cur_state(cur_state), .entry_count(entry_count), .attempts_left(attempts_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_out(input string tag, input int st, input int cnt, input int un,
                            input int lo, input int fp, input int att);
    check({tag, " state"},         int'(cur_state),     st);
    check({tag, " entry_count"},   int'(entry_count),   cnt);
    check({tag, " unlock"},        int'(unlock),        un);
    check({tag, " lockout"},       int'(lockout),       lo);
    check({tag, " fail_pulse"},    int'(fail_pulse),    fp);
    check({tag, " attempts_left"}, int'(attempts_left), att);
  endtask

  // Reference model: lock behaviour from the rules, entry and key held as digit queues.
  typedef enum int {M_IDLE = 0, M_ENTER = 1, M_STORE = 2, M_CHECK = 3,
                    M_UNLOCK = 4, M_FAIL = 5, M_LOCKOUT = 6} mode_t;
  mode_t      m_mode;
  int         m_entry[$];
  int         m_key[$];
  int         m_att;
  int         m_left;
  logic [3:0] m_prev;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_entry.delete();
    m_key.delete();
    m_att  = MAX_ATT;
    m_left = 0;
    m_prev = 4'b0000;
  endtask

  task automatic model_tick(input logic [3:0] b, input int d);
    logic [3:0] e;
    bit c, s, i, st, hit;
    e  = b & ~m_prev;
    m_prev = b;
    c  = e[3];
    s  = e[2] && !e[3];
    i  = e[1] && (e[3:2] == 2'b00);
    st = e[0] && (e[3:1] == 3'b000);
    case (m_mode)
      M_IDLE: begin
        if (i) begin
          m_entry.delete(); m_entry.push_back(d); m_mode = M_ENTER;
        end else if (st && (!REKEY || m_key.size() == 0)) begin
          m_entry.delete(); m_entry.push_back(d); m_mode = M_STORE;
        end
      end
      M_ENTER: begin
        if (c) begin m_entry.delete(); m_mode = M_IDLE; end
        else if (s) m_mode = M_CHECK;
        else if (i && m_entry.size() < MAX_LEN) m_entry.push_back(d);
      end
      M_STORE: begin
        if (c) begin m_entry.delete(); m_mode = M_IDLE; end
        else if (s) begin
          m_key = m_entry; m_att = MAX_ATT; m_entry.delete(); m_mode = M_IDLE;
        end else if (st && m_entry.size() < MAX_LEN) m_entry.push_back(d);
      end
      M_CHECK: begin
        hit = (m_key.size() != 0) && (m_entry.size() == m_key.size());
        if (hit) foreach (m_key[k]) if (m_entry[k] != m_key[k]) hit = 1'b0;
        m_entry.delete();
        if (hit) begin m_att = MAX_ATT; m_left = UN_CYC; m_mode = M_UNLOCK; end
        else begin if (m_att > 0) m_att--; m_mode = M_FAIL; end
      end
      M_FAIL: begin
        if (m_att == 0) begin m_left = LO_CYC; m_mode = M_LOCKOUT; end
        else m_mode = M_IDLE;
      end
      M_UNLOCK: begin
        if (c) m_mode = M_IDLE;
        else if (st && REKEY) begin
          m_entry.delete(); m_entry.push_back(d); m_mode = M_STORE;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_att = MAX_ATT; m_mode = M_IDLE; end
      end
    endcase
  endtask

  task automatic compare_model(input int cyc);
    string tag;
    tag = $sformatf("rnd%0d", cyc);
    expect_out(tag, int'(m_mode), m_entry.size(), int'(m_mode == M_UNLOCK),
               int'(m_mode == M_LOCKOUT), int'(m_mode == M_FAIL), m_att);
  endtask

  task automatic cycle(input logic [3:0] b, input logic [3:0] d);
    {cancel_btn, submit_btn, input_btn, store_btn} = b;
    digit = d;
    @(posedge clk);
    #1;
    model_tick(b, int'(d));
  endtask

  task automatic press(input logic [3:0] b, input logic [3:0] d);
    cycle(b, d);
    cycle(B_0, d);
  endtask

  task automatic do_reset(input logic [3:0] hold, input logic [3:0] d);
    system_reset_n = 1'b0;
    {cancel_btn, submit_btn, input_btn, store_btn} = hold;
    digit = d;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    system_reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] btn;
    logic [3:0] dig;
    logic [2:0] st;
    logic [2:0] cnt;
    logic       un;
  } vec_t;

  vec_t tbl [20];
  int   n_lo;

  initial begin
    // Store 3,7,1; enter 3,7,1; submit -> four unlock cycles from two edges after submit.
    tbl[0]  = '{B_ST, 4'd3, 3'd2, 3'd1, 1'b0};
    tbl[1]  = '{B_0,  4'd0, 3'd2, 3'd1, 1'b0};
    tbl[2]  = '{B_ST, 4'd7, 3'd2, 3'd2, 1'b0};
    tbl[3]  = '{B_0,  4'd0, 3'd2, 3'd2, 1'b0};
    tbl[4]  = '{B_ST, 4'd1, 3'd2, 3'd3, 1'b0};
    tbl[5]  = '{B_0,  4'd0, 3'd2, 3'd3, 1'b0};
    tbl[6]  = '{B_S,  4'd0, 3'd0, 3'd0, 1'b0};
    tbl[7]  = '{B_0,  4'd0, 3'd0, 3'd0, 1'b0};
    tbl[8]  = '{B_I,  4'd3, 3'd1, 3'd1, 1'b0};
    tbl[9]  = '{B_0,  4'd0, 3'd1, 3'd1, 1'b0};
    tbl[10] = '{B_I,  4'd7, 3'd1, 3'd2, 1'b0};
    tbl[11] = '{B_0,  4'd0, 3'd1, 3'd2, 1'b0};
    tbl[12] = '{B_I,  4'd1, 3'd1, 3'd3, 1'b0};
    tbl[13] = '{B_0,  4'd0, 3'd1, 3'd3, 1'b0};
    tbl[14] = '{B_S,  4'd0, 3'd3, 3'd3, 1'b0};
    tbl[15] = '{B_0,  4'd0, 3'd4, 3'd0, 1'b1};
    tbl[16] = '{B_0,  4'd0, 3'd4, 3'd0, 1'b1};
    tbl[17] = '{B_0,  4'd0, 3'd4, 3'd0, 1'b1};
    tbl[18] = '{B_0,  4'd0, 3'd4, 3'd0, 1'b1};
    tbl[19] = '{B_0,  4'd0, 3'd0, 3'd0, 1'b0};

    system_reset_n = 1'b0;
    {cancel_btn, submit_btn, input_btn, store_btn} = 4'b0000;
    digit = '0;
    model_reset();
    do_reset(B_0, 4'd0);
    expect_out("reset", 0, 0, 0, 0, 0, MAX_ATT);

    for (int k = 0; k < 20; k++) begin
      cycle(tbl[k].btn, tbl[k].dig);
      expect_out($sformatf("vec%0d", k), int'(tbl[k].st), int'(tbl[k].cnt),
                 int'(tbl[k].un), 0, 0, MAX_ATT);
    end

    // Two wrong entries against key 3,7,1 -> fail pulses, then lockout that ignores input.
    press(B_I, 4'd3);
    press(B_I, 4'd7);
    press(B_S, 4'd0);
    expect_out("wrong1", 5, 0, 0, 0, 1, 1);
    cycle(B_0, 4'd0);
    expect_out("wrong1 after", 0, 0, 0, 0, 0, 1);
    press(B_I, 4'd9);
    press(B_S, 4'd0);
    expect_out("wrong2", 5, 0, 0, 0, 1, 0);
    cycle(B_0, 4'd0);
    n_lo = int'(lockout);
    for (int k = 0; k < 8; k++) begin
      cycle((k % 2 == 0) ? B_I : B_0, 4'd2);
      if (lockout) n_lo++;
      check($sformatf("lockout%0d entry_count", k), int'(entry_count), 0);
    end
    check("lockout length", n_lo, LO_CYC);
    expect_out("lockout exit", 0, 0, 0, 0, 0, MAX_ATT);

    // Submit and cancel edges in the same cycle: cancel wins, no fail.
    press(B_I, 4'd3);
    cycle(B_C | B_S, 4'd0);
    expect_out("cancel+submit", 0, 0, 0, 0, 0, MAX_ATT);
    cycle(B_0, 4'd0);
    expect_out("cancel+submit after", 0, 0, 0, 0, 0, MAX_ATT);

    // Saturation at MAX_LEN: 1,2,3,4,9 matches key 1,2,3,4.
    do_reset(B_0, 4'd0);
    for (int k = 1; k <= 4; k++) press(B_ST, 4'(k));
    press(B_S, 4'd0);
    expect_out("key1234", 0, 0, 0, 0, 0, MAX_ATT);
    for (int k = 1; k <= 4; k++) press(B_I, 4'(k));
    press(B_I, 4'd9);
    check("saturate entry_count", int'(entry_count), MAX_LEN);
    press(B_S, 4'd0);
    expect_out("saturated unlock", 4, 0, 1, 0, 0, MAX_ATT);
    cycle(B_C, 4'd0);
    expect_out("unlock cancel", 0, 0, 0, 0, 0, MAX_ATT);
    cycle(B_0, 4'd0);

    // Store edges in IDLE with a key present and during UNLOCK.
    press(B_ST, 4'd5);
`ifdef LOCK_REKEY_EN
    expect_out("idle store ignored", 0, 0, 0, 0, 0, MAX_ATT);
`else
    expect_out("idle store", 2, 1, 0, 0, 0, MAX_ATT);
    press(B_C, 4'd0);
    expect_out("store cancel", 0, 0, 0, 0, 0, MAX_ATT);
`endif
    for (int k = 1; k <= 4; k++) press(B_I, 4'(k));
    press(B_S, 4'd0);
    expect_out("key kept unlock", 4, 0, 1, 0, 0, MAX_ATT);
    cycle(B_ST, 4'd5);
`ifdef LOCK_REKEY_EN
    expect_out("rekey from unlock", 2, 1, 0, 0, 0, MAX_ATT);
`else
    expect_out("unlock store ignored", 4, 0, 1, 0, 0, MAX_ATT);
`endif
    cycle(B_0, 4'd0);
    press(B_C, 4'd0);
    expect_out("rekey cancel", 0, 0, 0, 0, 0, MAX_ATT);

    // Reset in the middle of lockout, with input held through reset release.
    press(B_I, 4'd0);
    press(B_S, 4'd0);
    cycle(B_0, 4'd0);
    press(B_I, 4'd0);
    press(B_S, 4'd0);
    cycle(B_0, 4'd0);
    cycle(B_0, 4'd0);
    cycle(B_0, 4'd0);
    check("lockout cycle3", int'(lockout), 1);
    system_reset_n = 1'b0;
    #1;
    expect_out("async reset", 0, 0, 0, 0, 0, MAX_ATT);
    do_reset(B_I, 4'd1);
    cycle(B_I, 4'd1);
    expect_out("held input edge", 1, 1, 0, 0, 0, MAX_ATT);
    cycle(B_0, 4'd0);
    press(B_S, 4'd0);
    expect_out("no key fail", 5, 0, 0, 0, 1, MAX_ATT - 1);

    // Random stimulus against the model, with occasional resets holding buttons.
    do_reset(B_0, 4'd0);
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] b;
      logic [3:0] d;
      b[3] = ($urandom_range(0, 99) < 4);
      b[2] = ($urandom_range(0, 99) < 20);
      b[1] = ($urandom_range(0, 99) < 45);
      b[0] = ($urandom_range(0, 99) < 25);
      d    = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 799) == 0) do_reset(b, d);
      cycle(b, d);
      compare_model(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
